ysyx_23060062_idu: RTL and testbench

Decode stage for the ysyx_23060062 RV32I core. Each cycle it can accept one instruction word and PC from fetch, read rs1 from the integer register file it owns, and generate the sign-extended immediate. It registers the operation code, src1, imm and rd index toward the ALU stage, where the adder consumes `src1` and `imm`. Writeback from the ALU stage comes back into the register file through a write port, with same-cycle bypass to the rs1 read.

---
 rtl/ysyx_23060062_pkg.sv | 37 +++
 rtl/ysyx_23060062_regfile.sv | 34 +++
 rtl/ysyx_23060062_idu.sv | 133 +++++++++++++
 tb/tb_ysyx_23060062_idu.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060062_pkg.sv
// Shared decode definitions: op codes, base opcodes, EBREAK word and the
// decoded-operation bundle handed from decode to the ALU stage.
package ysyx_23060062_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_ADDI    = 4'd1,
    OP_SLTI    = 4'd2,
    OP_SLTIU   = 4'd3,
    OP_XORI    = 4'd4,
    OP_ORI     = 4'd5,
    OP_ANDI    = 4'd6,
    OP_SLLI    = 4'd7,
    OP_SRLI    = 4'd8,
    OP_SRAI    = 4'd9,
    OP_LUI     = 4'd10,
    OP_AUIPC   = 4'd11,
    OP_EBREAK  = 4'd12,
    OP_ILLEGAL = 4'd15
  } op_e;

  localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LUI     = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC   = 7'b0010111;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] src1;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
  } dec_t;

endpackage

// File: rtl/ysyx_23060062_regfile.sv
// 32x32 integer register file: async rs1 read with writeback bypass, sync write.
// x0 reads as zero and ignores writes.
module ysyx_23060062_regfile
  import ysyx_23060062_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_idx,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rs1_idx,
  output logic [31:0] rs1_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_idx != 5'd0)) begin
      regs[wb_idx] <= wb_data;
    end
  end

  // A write landing this edge is only visible to a same-cycle read via the bypass.
  always_comb begin
    rs1_data = regs[rs1_idx];
    if (rs1_idx == 5'd0)
      rs1_data = '0;
    else if (wb_en && (wb_idx == rs1_idx))
      rs1_data = wb_data;
  end

endmodule

// File: rtl/ysyx_23060062_idu.sv
// RV32I decode stage: 1-cycle registered output toward the ALU; input stalls
// while the held op is not consumed, and permanently after an accepted EBREAK.
module ysyx_23060062_idu
  import ysyx_23060062_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [31:0] out_src1,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [31:0] out_pc,
  input  logic        wb_en,
  input  logic [4:0]  wb_idx,
  input  logic [31:0] wb_data,
  output logic        halted
);

  logic [31:0] rs1_data;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        accept;
  dec_t        dec;
  dec_t        out_q;
  state_e      state_q, state_d;

  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  ysyx_23060062_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_idx   (wb_idx),
    .wb_data  (wb_data),
    .rs1_idx  (in_inst[19:15]),
    .rs1_data (rs1_data)
  );

  always_comb begin
    dec.op   = OP_ILLEGAL;
    dec.src1 = rs1_data;
    dec.imm  = '0;
    dec.rd   = in_inst[11:7];
    dec.pc   = in_pc;
    if (in_inst == EBREAK_WORD) begin
      dec.op   = OP_EBREAK;
      dec.rd   = '0;
      dec.src1 = '0;
    end else begin
      case (in_inst[6:0])
        OPC_OP_IMM: begin
          dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
          case (funct3)
            3'b000: dec.op = OP_ADDI;
            3'b010: dec.op = OP_SLTI;
            3'b011: dec.op = OP_SLTIU;
            3'b100: dec.op = OP_XORI;
            3'b110: dec.op = OP_ORI;
            3'b111: dec.op = OP_ANDI;
            3'b001: begin
              dec.imm = {27'b0, in_inst[24:20]};
              if (funct7 == 7'b0000000) dec.op = OP_SLLI;
            end
            3'b101: begin
              dec.imm = {27'b0, in_inst[24:20]};
              if (funct7 == 7'b0000000)      dec.op = OP_SRLI;
              else if (funct7 == 7'b0100000) dec.op = OP_SRAI;
            end
            default: dec.op = OP_ILLEGAL;
          endcase
        end
        OPC_LUI: begin
          dec.op   = OP_LUI;
          dec.imm  = {in_inst[31:12], 12'b0};
          dec.src1 = '0;
        end
        OPC_AUIPC: begin
          dec.op   = OP_AUIPC;
          dec.imm  = {in_inst[31:12], 12'b0};
          dec.src1 = in_pc;
        end
        default: dec.op = OP_ILLEGAL;
      endcase
    end
    // Illegal encodings travel downstream with a clean immediate.
    if (dec.op == OP_ILLEGAL) dec.imm = '0;
  end

  assign in_ready = !halted && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '{op: OP_NOP, src1: '0, imm: '0, rd: '0, pc: RESET_PC};
    end else if (accept) begin
      out_valid <= 1'b1;
      out_q     <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_op   = out_q.op;
  assign out_src1 = out_q.src1;
  assign out_imm  = out_q.imm;
  assign out_rd   = out_q.rd;
  assign out_pc   = out_q.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_RUN && accept && dec.op == OP_EBREAK) state_d = S_HALT;
  end

  always_comb begin
    halted = (state_q == S_HALT);
  end

endmodule

// File: tb/tb_ysyx_23060062_idu.sv
// Directed-vector bench for the decode stage; inputs change and outputs are
// sampled on the falling edge.
module tb_ysyx_23060062_idu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_src1;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        halted;

  int checks = 0;
  int errors = 0;

  ysyx_23060062_idu #(.RESET_PC(32'h8000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_src1  (out_src1),
    .out_imm   (out_imm),
    .out_rd    (out_rd),
    .out_pc    (out_pc),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] op, input logic [31:0] src1,
                            input logic [31:0] imm, input logic [4:0] rd);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".op"},    {28'b0, out_op}, {28'b0, op});
    chk({tag, ".src1"},  out_src1, src1);
    chk({tag, ".imm"},   out_imm, imm);
    chk({tag, ".rd"},    {27'b0, out_rd}, {27'b0, rd});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    out_ready = 1'b0; wb_en = 1'b0; wb_idx = '0; wb_data = '0;
    @(negedge clk);
    chk("rst.valid",  {31'b0, out_valid}, 32'd0);
    chk("rst.op",     {28'b0, out_op}, 32'd0);
    chk("rst.src1",   out_src1, 32'd0);
    chk("rst.imm",    out_imm, 32'd0);
    chk("rst.rd",     {27'b0, out_rd}, 32'd0);
    chk("rst.pc",     out_pc, 32'h8000_0000);
    chk("rst.halted", {31'b0, halted}, 32'd0);
    chk("rst.rdy",    {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    out_ready = 1'b1;
    present(32'h0050_0093, 32'h8000_0000); step();
    expect_out("addi5", 4'd1, 32'd0, 32'd5, 5'd1);
    chk("addi5.pc", out_pc, 32'h8000_0000);
    present(32'hFFF0_0113, 32'h8000_0004); step();
    expect_out("addim1", 4'd1, 32'd0, 32'hFFFF_FFFF, 5'd2);
    chk("addim1.pc", out_pc, 32'h8000_0004);
    present(32'h4033_5293, 32'h8000_0008); step();
    expect_out("srai", 4'd9, 32'd0, 32'd3, 5'd5);
    present(32'h0020_9093, 32'h8000_000C); step();
    expect_out("slli", 4'd7, 32'd0, 32'd2, 5'd1);
    present(32'h0200_9093, 32'h8000_0010); step();
    expect_out("slli_bad", 4'd15, 32'd0, 32'd0, 5'd1);
    present(32'h0000_0033, 32'h8000_0014); step();
    chk("rtype.op", {28'b0, out_op}, 32'd15);
    present(32'h8000_7093, 32'h8000_0018); step();
    expect_out("andi", 4'd6, 32'd0, 32'hFFFF_F800, 5'd1);

    // bypass write of x3 in the same cycle it is read, then read from storage
    wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'h0000_1234;
    present(32'h0011_8213, 32'h8000_0020); step();
    wb_en = 1'b0;
    expect_out("bypass", 4'd1, 32'h0000_1234, 32'd1, 5'd4);
    present(32'h0011_8213, 32'h8000_0024); step();
    chk("stored.src1", out_src1, 32'h0000_1234);

    wb_en = 1'b1; wb_idx = 5'd0; wb_data = 32'hDEAD_BEEF;
    present(32'h0000_0393, 32'h8000_0028); step();
    wb_en = 1'b0;
    chk("x0_bypass.src1", out_src1, 32'd0);
    present(32'h0000_0393, 32'h8000_002C); step();
    chk("x0_read.src1", out_src1, 32'd0);

    // LUI ignores rs1 field (x8) even when it is being written
    wb_en = 1'b1; wb_idx = 5'd8; wb_data = 32'h0000_5555;
    present(32'h1234_5437, 32'h8000_0030); step();
    wb_en = 1'b0;
    expect_out("lui", 4'd10, 32'd0, 32'h1234_5000, 5'd8);
    present(32'h0000_1497, 32'h8000_0100); step();
    expect_out("auipc", 4'd11, 32'h8000_0100, 32'h0000_1000, 5'd9);
    chk("auipc.pc", out_pc, 32'h8000_0100);

    // backpressure: A held for 3 cycles while B waits, B loads once released
    present(32'h00A0_0513, 32'h8000_0200); step();
    expect_out("bpA", 4'd1, 32'd0, 32'd10, 5'd10);
    present(32'h00B0_0593, 32'h8000_0204);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
      step();
      expect_out("bp.hold", 4'd1, 32'd0, 32'd10, 5'd10);
      chk("bp.hold.pc", out_pc, 32'h8000_0200);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release.rdy", {31'b0, in_ready}, 32'd1);
    step();
    expect_out("bpB", 4'd1, 32'd0, 32'd11, 5'd11);
    chk("bpB.pc", out_pc, 32'h8000_0204);

    // EBREAK halts one cycle after acceptance and stays halted
    present(32'h0010_0073, 32'h8000_0300); step();
    expect_out("ebreak", 4'd12, 32'd0, 32'd0, 5'd0);
    chk("ebreak.halted", {31'b0, halted}, 32'd1);
    chk("ebreak.rdy",    {31'b0, in_ready}, 32'd0);
    present(32'h0050_0093, 32'h8000_0304);
    wb_en = 1'b1; wb_idx = 5'd12; wb_data = 32'h77;
    step();
    wb_en = 1'b0;
    chk("halt.drained", {31'b0, out_valid}, 32'd0);
    chk("halt.rdy",     {31'b0, in_ready}, 32'd0);
    chk("halt.sticky",  {31'b0, halted}, 32'd1);
    step();
    chk("halt.rdy2",    {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b1; #2; rst = 1'b0;
    chk("unhalt.halted", {31'b0, halted}, 32'd0);
    chk("unhalt.rdy",    {31'b0, in_ready}, 32'd1);

    // async reset while holding an op; register file is cleared as well
    @(negedge clk);
    present(32'h0050_0093, 32'h8000_0400); step();
    in_valid = 1'b0;
    chk("pre_arst.valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1; #1;
    chk("arst.valid", {31'b0, out_valid}, 32'd0);
    chk("arst.pc",    out_pc, 32'h8000_0000);
    #1; rst = 1'b0;
    @(negedge clk);
    present(32'h0011_8213, 32'h8000_0500); step();
    expect_out("rf_cleared", 4'd1, 32'd0, 32'd1, 5'd4);
    in_valid = 1'b0;
    step();
    chk("idle.valid", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
